demux1b2_fifo: RTL and testbench
================================

# demux1b2_fifo

Registered 1-to-2 demultiplexer: the inverse of the existing 2:1 data mux. A single producer stream is steered by `ctrl` to one of two consumer channels (A when 0, B when 1), each buffered by a 2-entry FIFO with valid/ready handshakes. It sits between the multi-cycle datapath result bus and the two writeback paths (register/memory), decoupling producer and consumer timing.

## Interface
- `WIDTH`, 16: data width of input and both outputs.
- `CNT_W`, 8: width of per-channel delivered-transfer counters.

- `clk`  input  1  system clock, all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `ctrl`  input  1  destination select sampled with the input beat (0 → A, 1 → B).
- `data_in`  input  WIDTH  input beat data.
- `in_valid`  input  1  producer has a beat.
- `in_ready`  output  1  selected channel FIFO can accept (combinational).
- `data_A` / `data_B`  output  WIDTH  head entry of channel A/B FIFO.
- `valid_A` / `valid_B`  output  1  channel FIFO non-empty.
- `ready_A` / `ready_B`  input  1  consumer accepts head entry.
- `count_A` / `count_B`  output  CNT_W  delivered beats per channel.

## Operation
- Per channel: 2-entry storage, 1-bit write pointer, 1-bit read pointer, 2-bit occupancy (0..2).
- `in_ready = ctrl ? (occ_B != 2) : (occ_A != 2)`. No path from `ready_A/B` to `in_ready`.
- Push: `in_valid && in_ready` writes `data_in` into the channel selected by `ctrl`; that write pointer toggles.
- Pop: `valid_X && ready_X` advances read pointer X.
- Push and pop on the same channel in one cycle: occupancy unchanged, FIFO order preserved.
- Full channel with simultaneous pop: push still refused that cycle (in_ready already low).
- Push to one channel and pop from the other proceed independently.
- `valid_X = (occ_X != 0)`; `data_X` = storage[rd_ptr_X], registered, stable while `valid_X && !ready_X`.
- `data_X` when empty: holds last storage contents (don't-care for consumers).
- `in_valid` low: `ctrl`/`data_in` ignored.
- Counters increment by 1 on each pop of their channel; wrap 2^CNT_W−1 → 0.

## Timing
- Reset (synchronous): occ=0, pointers=0, storage=0, `valid_A/B`=0, `data_A/B`=0, `count_A/B`=0. `in_ready` is 1 during and after reset (FIFOs empty).
- Reset asserted mid-operation: all buffered beats discarded at that edge; handshakes in that cycle have no effect.
- Latency: beat accepted at edge N appears on `data_X` with `valid_X`=1 after edge N (visible in cycle N+1). Min latency 1 cycle.
- Throughput: 1 beat/cycle sustained per channel when consumer holds ready high.
- Back-pressure: consumer stalled → channel accepts exactly 2 beats, then `in_ready`=0 for that `ctrl`.
- Counter updates visible the cycle after the pop edge.

## Configuration
- `DEMUX1B2_COUNT_EN`: defined → `count_A/B` counters implemented as above. Undefined → counter logic removed, `count_A/B` tied to 0; all data/handshake behaviour identical.

## Test plan
- Reset: assert `reset` 2 cycles → `valid_A`=`valid_B`=0, `data_A`=`data_B`=0, counts 0, `in_ready`=1.
- Steer: ready_A=ready_B=1; push 100 with ctrl=0, then 200 with ctrl=1 → `data_A`=100 valid one cycle after first edge, `data_B`=200 one cycle after second; `count_A`=`count_B`=1.
- Back-pressure: ready_A=0, push 1,2,3 to A → first two accepted, `in_ready`=0 on third; raise ready_A → pops 1 then 2, then 3 accepted.
- Full+pop: A full (10,11), ready_A=1 and push 12 same cycle → 12 refused; next cycle accepted; output order 10,11,12.
- Wrap/order: 256 pops on B with ready_B=1 → `count_B` wraps to 0 (COUNT_EN defined); with macro undefined → `count_B` stays 0.
- Mid-op reset: A holding 2 beats, assert reset → next cycle `valid_A`=0, `count_A`=0, later push 55 delivered alone.

Source files
------------

// File: rtl/demux1b2_fifo.sv
// demux1b2_fifo: ctrl-steered 1:2 demux into two 2-entry valid/ready FIFOs; DEMUX1B2_COUNT_EN enables per-channel pop counters
module demux1b2_fifo #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_A,
  output logic [WIDTH-1:0] data_B,
  output logic             valid_A,
  output logic             valid_B,
  input  logic             ready_A,
  input  logic             ready_B,
  output logic [CNT_W-1:0] count_A,
  output logic [CNT_W-1:0] count_B
);
  logic [WIDTH-1:0] mem_a [2];
  logic [WIDTH-1:0] mem_b [2];
  logic wp_a, rp_a, wp_b, rp_b;
  logic [1:0] occ_a, occ_b;
  logic push_a, push_b, pop_a, pop_b;
  // in_ready depends only on occupancy, never on consumer ready
  assign in_ready = ctrl ? (occ_b != 2'd2) : (occ_a != 2'd2);
  assign push_a = in_valid && in_ready && !ctrl;
  assign push_b = in_valid && in_ready && ctrl;
  assign valid_A = occ_a != 2'd0;
  assign valid_B = occ_b != 2'd0;
  assign pop_a = valid_A && ready_A;
  assign pop_b = valid_B && ready_B;
  assign data_A = mem_a[rp_a];
  assign data_B = mem_b[rp_b];
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_a[0] <= '0;
      mem_a[1] <= '0;
      mem_b[0] <= '0;
      mem_b[1] <= '0;
      wp_a <= 1'b0;
      rp_a <= 1'b0;
      wp_b <= 1'b0;
      rp_b <= 1'b0;
      occ_a <= 2'd0;
      occ_b <= 2'd0;
    end else begin
      if (push_a) mem_a[wp_a] <= data_in;
      if (push_b) mem_b[wp_b] <= data_in;
      wp_a <= wp_a ^ push_a;
      wp_b <= wp_b ^ push_b;
      rp_a <= rp_a ^ pop_a;
      rp_b <= rp_b ^ pop_b;
      occ_a <= occ_a + {1'b0, push_a} - {1'b0, pop_a};
      occ_b <= occ_b + {1'b0, push_b} - {1'b0, pop_b};
    end
  end
`ifdef DEMUX1B2_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      count_A <= '0;
      count_B <= '0;
    end else begin
      count_A <= count_A + CNT_W'(pop_a);
      count_B <= count_B + CNT_W'(pop_b);
    end
  end
`else
  assign count_A = '0;
  assign count_B = '0;
`endif
endmodule

// File: tb/tb_demux1b2_fifo.sv
// tb_demux1b2_fifo: table-driven and directed self-checking bench for demux1b2_fifo
module tb_demux1b2_fifo;
  localparam int W = 16;
  localparam int CW = 8;
`ifdef DEMUX1B2_COUNT_EN
  localparam int CE = 1;
`else
  localparam int CE = 0;
`endif
  logic clk = 1'b0;
  logic reset, ctrl, in_valid, in_ready, valid_A, valid_B, ready_A, ready_B;
  logic [W-1:0] data_in, data_A, data_B;
  logic [CW-1:0] count_A, count_B;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  demux1b2_fifo #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .ctrl(ctrl), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .data_A(data_A), .data_B(data_B), .valid_A(valid_A),
    .valid_B(valid_B), .ready_A(ready_A), .ready_B(ready_B),
    .count_A(count_A), .count_B(count_B)
  );
  typedef struct {
    logic c; logic [15:0] d; logic v, ra, rb;
    logic rdy, va; logic [15:0] da; logic vb; logic [15:0] db; int ca, cb;
  } vec_t;
  vec_t tbl [18];
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic c, input logic [15:0] d, input logic v,
                       input logic ra, input logic rb);
    reset = r; ctrl = c; data_in = d; in_valid = v; ready_A = ra; ready_B = rb;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    //          c  d    v  ra rb rdy va da   vb db   ca cb
    tbl[0]  = '{0, 100, 1, 1, 1, 1,  1, 100, 0, 0,   0, 0};
    tbl[1]  = '{1, 200, 1, 1, 1, 1,  0, 0,   1, 200, 1, 0};
    tbl[2]  = '{0, 0,   0, 1, 1, 1,  0, 0,   0, 0,   1, 1};
    tbl[3]  = '{0, 1,   1, 0, 0, 1,  1, 1,   0, 0,   1, 1};
    tbl[4]  = '{0, 2,   1, 0, 0, 1,  1, 1,   0, 0,   1, 1};
    tbl[5]  = '{0, 3,   1, 0, 0, 0,  1, 1,   0, 0,   1, 1};
    tbl[6]  = '{0, 3,   1, 1, 0, 0,  1, 2,   0, 0,   2, 1};
    tbl[7]  = '{0, 3,   1, 1, 0, 1,  1, 3,   0, 0,   3, 1};
    tbl[8]  = '{0, 0,   0, 1, 0, 1,  0, 2,   0, 0,   4, 1};
    tbl[9]  = '{0, 10,  1, 0, 0, 1,  1, 10,  0, 0,   4, 1};
    tbl[10] = '{0, 11,  1, 0, 0, 1,  1, 10,  0, 0,   4, 1};
    tbl[11] = '{0, 12,  1, 1, 0, 0,  1, 11,  0, 0,   5, 1};
    tbl[12] = '{0, 12,  1, 1, 0, 1,  1, 12,  0, 0,   6, 1};
    tbl[13] = '{0, 0,   0, 1, 0, 1,  0, 11,  0, 0,   7, 1};
    tbl[14] = '{1, 7,   1, 0, 0, 1,  0, 11,  1, 7,   7, 1};
    tbl[15] = '{0, 8,   1, 0, 1, 1,  1, 8,   0, 200, 7, 2};
    tbl[16] = '{1, 9,   1, 1, 0, 1,  0, 12,  1, 9,   8, 2};
    tbl[17] = '{0, 0,   0, 1, 1, 1,  0, 12,  0, 7,   8, 3};
    drive(1, 0, 16'hbeef, 0, 0, 0);
    tick;
    tick;
    check("rst valid_A", 32'(valid_A), 0);
    check("rst valid_B", 32'(valid_B), 0);
    check("rst data_A", 32'(data_A), 0);
    check("rst data_B", 32'(data_B), 0);
    check("rst count_A", 32'(count_A), 0);
    check("rst count_B", 32'(count_B), 0);
    check("rst in_ready c0", 32'(in_ready), 1);
    ctrl = 1'b1;
    #1;
    check("rst in_ready c1", 32'(in_ready), 1);
    for (int i = 0; i < 18; i++) begin
      drive(0, tbl[i].c, tbl[i].d, tbl[i].v, tbl[i].ra, tbl[i].rb);
      #1;
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      tick;
      check($sformatf("v%0d valid_A", i), 32'(valid_A), 32'(tbl[i].va));
      check($sformatf("v%0d data_A", i), 32'(data_A), 32'(tbl[i].da));
      check($sformatf("v%0d valid_B", i), 32'(valid_B), 32'(tbl[i].vb));
      check($sformatf("v%0d data_B", i), 32'(data_B), 32'(tbl[i].db));
      check($sformatf("v%0d count_A", i), 32'(count_A), 32'(tbl[i].ca * CE));
      check($sformatf("v%0d count_B", i), 32'(count_B), 32'(tbl[i].cb * CE));
    end
    // mid-operation reset with two beats held in A and a handshake offered
    drive(0, 0, 41, 1, 0, 0);
    tick;
    drive(0, 0, 42, 1, 0, 0);
    tick;
    check("midrst A full", 32'(in_ready), 0);
    drive(1, 0, 77, 1, 1, 1);
    tick;
    check("midrst valid_A", 32'(valid_A), 0);
    check("midrst data_A", 32'(data_A), 0);
    check("midrst valid_B", 32'(valid_B), 0);
    check("midrst count_A", 32'(count_A), 0);
    check("midrst count_B", 32'(count_B), 0);
    drive(0, 0, 0, 0, 0, 0);
    tick;
    check("midrst idle valid_A", 32'(valid_A), 0);
    drive(0, 0, 55, 1, 0, 0);
    tick;
    check("post55 valid_A", 32'(valid_A), 1);
    check("post55 data_A", 32'(data_A), 55);
    drive(0, 0, 0, 0, 1, 0);
    tick;
    check("post55 drained", 32'(valid_A), 0);
    check("post55 count_A", 32'(count_A), 32'(CE));
    // sustained streaming into B: 256 pops exercise the counter wrap
    for (int i = 0; i < 256; i++) begin
      drive(0, 1, 16'(i * 3 + 5), 1, 0, 1);
      #1;
      check($sformatf("stream%0d in_ready", i), 32'(in_ready), 1);
      tick;
      check($sformatf("stream%0d valid_B", i), 32'(valid_B), 1);
      check($sformatf("stream%0d data_B", i), 32'(data_B), 32'(16'(i * 3 + 5)));
    end
    check("wrap count_B 255", 32'(count_B), 32'(255 * CE));
    drive(0, 1, 0, 0, 0, 1);
    tick;
    check("wrap valid_B", 32'(valid_B), 0);
    check("wrap count_B 0", 32'(count_B), 0);
    check("wrap count_A", 32'(count_A), 32'(CE));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
